// File: rtl/bp_be_pkg.sv
// rtl/bp_be_pkg.sv - shared backend types and width helpers for the integer issue arbiter
package bp_be_pkg;

  typedef enum logic [1:0] {
    e_bp_default_cfg = 2'd0
  } bp_params_e;

  typedef enum logic [0:0] {
    e_issue_src_main   = 1'b0,
    e_issue_src_replay = 1'b1
  } bp_be_issue_src_e;

  typedef enum logic [0:0] {
    e_empty = 1'b0,
    e_full  = 1'b1
  } bp_be_issue_arb_state_e;

  function automatic int bp_vaddr_width(bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return 39;
      default:          return 39;
    endcase
  endfunction

  // Reservation layout: {v, pc[vaddr], instr[32]}
  function automatic int bp_be_reservation_width(bp_params_e cfg);
    return bp_vaddr_width(cfg) + 33;
  endfunction

  function automatic int safe_clog2(int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bsg_arb_round_robin.sv
// rtl/bsg_arb_round_robin.sv - plain rotating one-hot grant starting at a supplied pointer
module bsg_arb_round_robin
  #(parameter int width_p     = 2
  , parameter int ptr_width_p = 1)
  (input  logic [width_p-1:0]     reqs_i
  , input  logic [ptr_width_p-1:0] ptr_i
  , output logic [width_p-1:0]     grants_o);

  // First requester at or after the pointer, wrapping around
  always_comb begin
    logic found;
    grants_o = '0;
    found    = 1'b0;
    for (int j = 0; j < width_p; j++) begin
      int idx;
      idx = int'(ptr_i) + j;
      if (idx >= width_p) idx = idx - width_p;
      if (!found && reqs_i[idx[ptr_width_p-1:0]]) begin
        grants_o[idx[ptr_width_p-1:0]] = 1'b1;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bp_be_pipe_int_issue_arb.sv
// rtl/bp_be_pipe_int_issue_arb.sv - starvation-bounded round-robin issue arbiter with one-entry stage
module bp_be_pipe_int_issue_arb
  import bp_be_pkg::*;
  #(parameter bp_params_e bp_params_p = e_bp_default_cfg
  , parameter int num_req_p      = 2
  , parameter int starve_limit_p = 4
  , parameter int ctr_width_p    = 16
  , localparam int reservation_width_lp = bp_be_reservation_width(bp_params_p)
  , localparam int id_width_lp          = safe_clog2(num_req_p))
  (input  logic                                      clk_i
  , input  logic                                     reset_i
  , input  logic                                     flush_i
  , input  logic [num_req_p-1:0]                     req_v_i
  , input  logic [num_req_p*reservation_width_lp-1:0] req_reservation_i
  , output logic [num_req_p-1:0]                     req_ready_and_o
  , input  logic                                     pipe_ready_i
  , output logic                                     v_o
  , output logic [reservation_width_lp-1:0]          reservation_o
  , output logic [id_width_lp-1:0]                   grant_id_o
  , output logic [num_req_p*ctr_width_p-1:0]         issue_count_o);

  localparam int starve_width_lp = $clog2(starve_limit_p + 1);

  bp_be_issue_arb_state_e                    state_r;
  logic [id_width_lp-1:0]                    ptr_r;
  logic [num_req_p-1:0][starve_width_lp-1:0] starve_r;
  logic [num_req_p-1:0][ctr_width_p-1:0]     count_r;

  logic                            accept, grant_v, deliver;
  logic [num_req_p-1:0]            starved, rr_grant, grant;
  logic [id_width_lp-1:0]          winner, ptr_next;
  logic [reservation_width_lp-1:0] sel_res;

  assign v_o           = (state_r == e_full);
  assign issue_count_o = count_r;
  assign accept  = ((state_r == e_empty) | pipe_ready_i) & ~flush_i & ~reset_i;
  assign deliver = v_o & pipe_ready_i & ~flush_i;

  // Valid requesters that have lost starve_limit_p times in a row
  always_comb begin
    starved = '0;
    for (int i = 0; i < num_req_p; i++)
      starved[i] = req_v_i[i] & (starve_r[i] == starve_width_lp'(starve_limit_p));
  end

  bsg_arb_round_robin #(.width_p(num_req_p), .ptr_width_p(id_width_lp)) rr
    (.reqs_i(req_v_i), .ptr_i(ptr_r), .grants_o(rr_grant));

  // Lowest-index starved requester overrides the rotating choice
  assign grant = ~accept ? '0
               : (|starved) ? (starved & (~starved + num_req_p'(1)))
               : rr_grant;
  assign grant_v         = |grant;
  assign req_ready_and_o = grant;

  // Encode the winner and select its reservation
  always_comb begin
    winner  = '0;
    sel_res = '0;
    for (int i = 0; i < num_req_p; i++) begin
      if (grant[i]) begin
        winner  = id_width_lp'(i);
        sel_res = req_reservation_i[i*reservation_width_lp +: reservation_width_lp];
      end
    end
  end

  assign ptr_next = (winner == id_width_lp'(num_req_p - 1)) ? '0 : winner + id_width_lp'(1);

  // Stage register and rotation pointer
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r       <= e_empty;
      reservation_o <= '0;
      grant_id_o    <= '0;
      ptr_r         <= '0;
    end else begin
      if (flush_i) begin
        state_r <= e_empty;
      end else if (grant_v) begin
        state_r       <= e_full;
        reservation_o <= sel_res;
        grant_id_o    <= winner;
      end else if (pipe_ready_i) begin
        state_r <= e_empty;
      end
      if (grant_v) ptr_r <= ptr_next;
    end
  end

  // Starvation counters: count losses to others, clear on own grant or idle, hold on stall
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      starve_r <= '0;
    end else begin
      for (int i = 0; i < num_req_p; i++) begin
        if (grant[i] | ~req_v_i[i])
          starve_r[i] <= '0;
        else if (grant_v && (starve_r[i] != starve_width_lp'(starve_limit_p)))
          starve_r[i] <= starve_r[i] + starve_width_lp'(1);
      end
    end
  end

  // Saturating per-source delivery counters
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_r <= '0;
    end else begin
      for (int i = 0; i < num_req_p; i++)
        if (deliver && (grant_id_o == id_width_lp'(i)) && (count_r[i] != '1))
          count_r[i] <= count_r[i] + ctr_width_p'(1);
    end
  end

endmodule

// File: tb/tb_bp_be_pipe_int_issue_arb.sv
// tb/tb_bp_be_pipe_int_issue_arb.sv - reference-model bench for the integer issue arbiter
module tb_bp_be_pipe_int_issue_arb;
  import bp_be_pkg::*;

  localparam int W  = bp_be_reservation_width(e_bp_default_cfg);
  localparam int CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, flush, pready;
  logic [3:0]   vin [2];
  logic [W-1:0] rin [2][4];

  logic [1:0]      rdy2, gid2;
  logic [2:0]      rdy3;
  logic [1:0]      gid3;
  logic            vo2, vo3;
  logic [W-1:0]    ro2, ro3;
  logic [2*CW-1:0] cnt2;
  logic [3*CW-1:0] cnt3;
  logic [0:0]      gid2_raw;

  bp_be_pipe_int_issue_arb dut2
    (.clk_i(clk), .reset_i(reset), .flush_i(flush), .req_v_i(vin[0][1:0])
    , .req_reservation_i({rin[0][1], rin[0][0]}), .req_ready_and_o(rdy2)
    , .pipe_ready_i(pready), .v_o(vo2), .reservation_o(ro2), .grant_id_o(gid2_raw)
    , .issue_count_o(cnt2));

  bp_be_pipe_int_issue_arb #(.num_req_p(3), .starve_limit_p(1)) dut3
    (.clk_i(clk), .reset_i(reset), .flush_i(flush), .req_v_i(vin[1][2:0])
    , .req_reservation_i({rin[1][2], rin[1][1], rin[1][0]}), .req_ready_and_o(rdy3)
    , .pipe_ready_i(pready), .v_o(vo3), .reservation_o(ro3), .grant_id_o(gid3)
    , .issue_count_o(cnt3));

  assign gid2 = {1'b0, gid2_raw};

  int checks = 0;
  int errors = 0;

  int n   [2] = '{2, 3};
  int lim [2] = '{4, 1};
  bit           mv   [2];
  logic [W-1:0] mres [2];
  int mid [2];
  int ptr [2];
  int st  [2][4];
  int cnt [2][4];

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] dut_cnt(int k, int i);
    if (k == 0) return (i < 2) ? cnt2[i*CW +: CW] : '0;
    return (i < 3) ? cnt3[i*CW +: CW] : '0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mv[k] = 0; mres[k] = '0; mid[k] = 0; ptr[k] = 0;
      for (int i = 0; i < 4; i++) begin st[k][i] = 0; cnt[k][i] = 0; end
    end
  endtask

  task automatic new_res();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4; i++) begin
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        rin[k][i] = t[W-1:0];
      end
  endtask

  // One clock: check outputs at the negedge against the model, then advance the model
  task automatic step();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      int N, w;
      bit acc;
      logic [3:0] eg;
      N = n[k];
      w = -1;
      acc = (!mv[k] || pready) && !flush && !reset;
      if (acc) begin
        for (int i = 0; i < N; i++)
          if (w < 0 && vin[k][i] && st[k][i] == lim[k]) w = i;
        for (int j = 0; j < N; j++) begin
          int i;
          i = (ptr[k] + j) % N;
          if (w < 0 && vin[k][i]) w = i;
        end
      end
      eg = (w >= 0) ? 4'(1 << w) : 4'b0;
      chk($sformatf("k%0d grant", k), (k == 0) ? {2'b0, rdy2} : {1'b0, rdy3}, eg);
      chk($sformatf("k%0d v_o", k), (k == 0) ? vo2 : vo3, mv[k]);
      chk($sformatf("k%0d reservation", k), (k == 0) ? ro2 : ro3, mres[k]);
      chk($sformatf("k%0d grant_id", k), (k == 0) ? gid2 : gid3, mid[k]);
      for (int i = 0; i < N; i++)
        chk($sformatf("k%0d count%0d", k, i), dut_cnt(k, i), cnt[k][i]);

      if (reset) begin
        mv[k] = 0; mres[k] = '0; mid[k] = 0; ptr[k] = 0;
        for (int i = 0; i < 4; i++) begin st[k][i] = 0; cnt[k][i] = 0; end
      end else begin
        if (mv[k] && pready && !flush && cnt[k][mid[k]] < 65535) cnt[k][mid[k]]++;
        for (int i = 0; i < N; i++) begin
          if (!vin[k][i] || i == w) st[k][i] = 0;
          else if (w >= 0 && st[k][i] < lim[k]) st[k][i]++;
        end
        if (w >= 0) ptr[k] = (w + 1) % N;
        if (flush) mv[k] = 0;
        else if (w >= 0) begin mv[k] = 1; mres[k] = rin[k][w]; mid[k] = w; end
        else if (pready) mv[k] = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; pready = 1'b0;
    vin[0] = 4'b0; vin[1] = 4'b0;
    new_res();
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    // reset held with requests present: no handshakes, reset outputs
    vin[0] = 4'b0011; vin[1] = 4'b0111;
    repeat (2) step();

    // both valid, pipe always ready: alternating grants, no bubbles
    reset = 1'b0; pready = 1'b1;
    repeat (9) begin new_res(); step(); end
    chk("burst count0", dut_cnt(0, 0), 4);
    chk("burst count1", dut_cnt(0, 1), 4);

    // only replay valid, then main joins and wins on the pointer
    vin[0] = 4'b0010; vin[1] = 4'b0010;
    repeat (3) begin new_res(); step(); end
    vin[0] = 4'b0011; vin[1] = 4'b0111;
    #1;
    chk("join grant main", {2'b0, rdy2}, 4'b0001);
    step();

    // downstream stall with everyone waiting
    pready = 1'b0;
    repeat (5) begin new_res(); step(); end
    pready = 1'b1;
    repeat (3) begin new_res(); step(); end

    // flush while full and downstream ready
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush v_o", vo2, 1'b0);
    repeat (3) begin new_res(); step(); end

    // reset pulse while full with requests present
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("reset pulse v_o", vo2, 1'b0);
    chk("reset pulse count", cnt2, '0);
    repeat (2) begin new_res(); step(); end

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      vin[0] = 4'($urandom_range(0, 3));
      vin[1] = 4'($urandom_range(0, 7));
      pready = ($urandom_range(0, 3) != 0);
      flush  = ($urandom_range(0, 15) == 0);
      reset  = ($urandom_range(0, 79) == 0);
      new_res();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
